// File: rtl/dco_fmeter_pkg.sv
// Shared types and helpers for the DCO frequency meter.
`timescale 1ps/1ps
package dco_fmeter_pkg;

   // Measurement sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      GATE = 2'd2,
      HOLD = 2'd3
   } fmeter_state_t;

   // Width of the gate down-counter. It only ever holds GATE_CYCLES-1, so
   // $clog2(GATE_CYCLES) bits are enough (GATE_CYCLES >= 2 gives >= 1 bit).
   function automatic int gate_cnt_w(input int gate_cycles);
      return $clog2(gate_cycles);
   endfunction

endpackage

// File: rtl/dco_freq_meter_edge_sync_det.sv
// edge_sync_det: brings an asynchronous oscillator into the clk domain through
// a SYNC_STAGES flop chain and emits a one-cycle pulse per synchronized rise.
`timescale 1ps/1ps
module edge_sync_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   // Synchronizer chain plus one extra flop holding the previous synchronized level.
   // NOTE: non-blocking assignments make every stage sample the old value of the
   // stage before it; blocking ones would collapse the chain into a single flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d_async};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/dco_freq_meter.sv
// dco_freq_meter: counts rising edges of an asynchronous DCO output over a
// window of GATE_CYCLES clk cycles and presents the count with a valid/ready
// handshake. Define DCO_FMETER_CONT_EN to re-arm automatically after every
// accepted result (continuous mode); otherwise each result needs a start.
`timescale 1ps/1ps
module dco_freq_meter
   import dco_fmeter_pkg::*;
#(
   parameter int GATE_CYCLES = 1000,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             osc_in,
   output logic             busy,
   output logic [CNT_W-1:0] count_out,
   output logic             count_valid,
   input  logic             count_ready,
   output logic             overflow
);

   localparam int             GW        = gate_cnt_w(GATE_CYCLES);
   localparam logic [GW-1:0]  GATE_LOAD = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   fmeter_state_t    state, state_nxt;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_cnt, edge_nxt;
   logic             ovf_flag, ovf_nxt;
   logic             rise;
   logic             handshake;
   logic             gate_done;

   edge_sync_det #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync_det (
      .clk     (clk),
      .rst     (rst),
      .d_async (osc_in),
      .rise    (rise)
   );

   assign handshake = count_valid & count_ready;
   assign gate_done = (state == GATE) && (gate_cnt == '0);
   assign busy      = (state != IDLE);

   // Saturating increment of the edge count; a rise at full scale sets overflow.
   // NOTE: every signal driven here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      edge_nxt = edge_cnt;
      ovf_nxt  = ovf_flag;
      if (rise) begin
         if (edge_cnt == CNT_MAX) ovf_nxt  = 1'b1;
         else                     edge_nxt = edge_cnt + CNT_W'(1);
      end
   end

   // Sequencer next state: one ARM cycle, GATE_CYCLES of GATE, HOLD until accepted.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = ARM;
         ARM:  state_nxt = GATE;
         GATE: if (gate_cnt == '0) state_nxt = HOLD;
         HOLD: if (handshake) begin
`ifdef DCO_FMETER_CONT_EN
            state_nxt = ARM;
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Gate down-counter and edge counter: cleared in ARM, active only in GATE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         ovf_flag <= 1'b0;
      end else if (state == ARM) begin
         gate_cnt <= GATE_LOAD;
         edge_cnt <= '0;
         ovf_flag <= 1'b0;
      end else if (state == GATE) begin
         if (gate_cnt != '0) gate_cnt <= gate_cnt - GW'(1);
         edge_cnt <= edge_nxt;
         ovf_flag <= ovf_nxt;
      end
   end

   // Result registers: captured on the last GATE cycle (including that cycle's
   // pulse) and held until the consumer accepts them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_out   <= '0;
         overflow    <= 1'b0;
         count_valid <= 1'b0;
      end else if (gate_done) begin
         count_out   <= edge_nxt;
         overflow    <= ovf_nxt;
         count_valid <= 1'b1;
      end else if (handshake) begin
         count_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dco_freq_meter.sv
// Self-checking bench for dco_freq_meter. Three instances: the default
// configuration, a 6-bit counter copy sharing its stimulus, and a small
// GATE_CYCLES=8 / CNT_W=2 copy driven synchronously for exact window checks.
`timescale 1ps/1ps
module tb_dco_freq_meter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, osc = 1'b0, ready = 1'b0;
   logic start_s = 1'b0, osc_s = 1'b0, ready_s = 1'b0;

   logic        busy, count_valid, overflow;
   logic [15:0] count_out;
   logic        busy6, valid6, ovf6;
   logic [5:0]  cout6;
   logic        busy_s, valid_s, ovf_s;
   logic [1:0]  cout_s;

   int osc_half = 0;   // oscillator half period in ps, 0 = held low
   int n_tests  = 0;
   int n_fail   = 0;

   dco_freq_meter #(.GATE_CYCLES(1000), .CNT_W(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .osc_in(osc), .busy(busy),
      .count_out(count_out), .count_valid(count_valid), .count_ready(ready),
      .overflow(overflow));

   dco_freq_meter #(.GATE_CYCLES(1000), .CNT_W(6), .SYNC_STAGES(2)) dut6 (
      .clk(clk), .rst(rst), .start(start), .osc_in(osc), .busy(busy6),
      .count_out(cout6), .count_valid(valid6), .count_ready(ready),
      .overflow(ovf6));

   dco_freq_meter #(.GATE_CYCLES(8), .CNT_W(2), .SYNC_STAGES(2)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .osc_in(osc_s), .busy(busy_s),
      .count_out(cout_s), .count_valid(valid_s), .count_ready(ready_s),
      .overflow(ovf_s));

   // 1 GHz system clock.
   always #500 clk = ~clk;

   // Free-running oscillator, offset so its edges do not line up with clk.
   initial begin
      #137;
      forever begin
         if (osc_half == 0) begin
            osc = 1'b0;
            #250;
         end else begin
            #(osc_half) osc = ~osc;
         end
      end
   end

   task automatic check(input string name, input int act, input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Wait (bounded) for count_valid on the main instance; n counts clk edges.
   task automatic wait_result(output int n);
      n = 0;
      while (!count_valid && n < 3000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check("result_timeout", int'(count_valid), 1, 1);
   endtask

   // Pulse start for one cycle and wait for the result; lat = cycles to valid.
   task automatic measure(output int lat);
      int n;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_result(n);
      lat = n + 1;
   endtask

   task automatic accept();
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   typedef struct {
      logic [0:13] pat;      // osc_s level per cycle, index 2 is the start cycle
      int          exp_cnt;
      int          exp_ovf;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int lat;
      int c0;
      int stable;

      // Window is cycles 2..9 of the pattern; rises there count, others are dropped.
      vecs[0] = '{14'b00000000000000, 0, 0};  // no edges
      vecs[1] = '{14'b00100000000000, 1, 0};  // rise in first GATE cycle
      vecs[2] = '{14'b01000000000000, 0, 0};  // rise lands in ARM
      vecs[3] = '{14'b00000000010000, 1, 0};  // rise in last GATE cycle
      vecs[4] = '{14'b00000000001000, 0, 0};  // rise lands in HOLD
      vecs[5] = '{14'b00101000000000, 2, 0};
      vecs[6] = '{14'b00101010100000, 3, 1};  // four rises saturate a 2-bit count
      vecs[7] = '{14'b00101010000000, 3, 0};  // exactly full scale, no overflow
      vecs[8] = '{14'b11111111111111, 0, 0};  // rise lands in IDLE
      vecs[9] = '{14'b00110011001100, 2, 0};  // third rise lands in HOLD

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_busy",  int'(busy), 0, 0);
      check("rst_valid", int'(count_valid), 0, 0);
      check("rst_ovf",   int'(overflow), 0, 0);
      check("rst_count", int'(count_out), 0, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

`ifdef DCO_FMETER_CONT_EN
      // Continuous mode: ready tied high, oscillator stepped 100 -> 200 MHz.
      ready    = 1'b1;
      osc_half = 5000;
      measure(lat);
      check("cont_lat",     lat, 1002, 1002);
      check("cont_cnt_100", int'(count_out), 99, 101);
      osc_half = 2500;
      @(posedge clk);
      @(negedge clk);
      check("cont_busy", int'(busy), 1, 1);
      wait_result(lat);
      check("cont_lat2",    lat, 1001, 1001);
      check("cont_cnt_200", int'(count_out), 198, 202);
      @(posedge clk);
      @(negedge clk);
      wait_result(lat);
      check("cont_cnt_200b", int'(count_out), 199, 201);
      check("cont_busy2", int'(busy), 1, 1);
      check("cont_ovf",   int'(overflow), 0, 0);
`else
      // 100 MHz: latency, count, overflow; 6-bit copy saturates.
      osc_half = 5000;
      measure(lat);
      check("lat_100",  lat, 1002, 1002);
      check("cnt_100",  int'(count_out), 99, 101);
      check("ovf_100",  int'(overflow), 0, 0);
      check("cnt6_100", int'(cout6), 63, 63);
      check("ovf6_100", int'(ovf6), 1, 1);
      check("val6_100", int'(valid6), 1, 1);

      // Consumer stalls for 50 cycles; start during HOLD is ignored.
      c0 = int'(count_out);
      stable = 1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         start = (i == 20);
         if (!count_valid || int'(count_out) != c0) stable = 0;
      end
      @(negedge clk);
      start = 1'b0;
      check("stall_stable", stable, 1, 1);
      check("stall_busy",   int'(busy), 1, 1);
      accept();
      check("accept_busy",  int'(busy), 0, 0);
      check("accept_valid", int'(count_valid), 0, 0);
      repeat (3) @(negedge clk);
      check("idle_after_accept", int'(busy), 0, 0);

      // Oscillator held low; accept with start high in the same cycle.
      osc_half = 0;
      measure(lat);
      check("cnt_zero", int'(count_out), 0, 0);
      check("ovf_zero", int'(overflow), 0, 0);
      @(negedge clk);
      start = 1'b1;
      ready = 1'b1;
      @(negedge clk);
      check("start_in_hold_busy", int'(busy), 0, 0);
      start = 1'b0;
      ready = 1'b0;
      @(negedge clk);
      check("start_in_hold_idle", int'(busy), 0, 0);

      // 400 MHz.
      osc_half = 1250;
      measure(lat);
      check("cnt_400", int'(count_out), 399, 401);
      check("ovf_400", int'(overflow), 0, 0);
      accept();

      // Asynchronous reset 500 cycles into GATE, then a normal measurement.
      osc_half = 5000;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (501) @(negedge clk);
      check("pre_rst_busy", int'(busy), 1, 1);
      #100 rst = 1'b1;
      #10;
      check("async_rst_busy",  int'(busy), 0, 0);
      check("async_rst_valid", int'(count_valid), 0, 0);
      check("async_rst_count", int'(count_out), 0, 0);
      check("async_rst_ovf",   int'(overflow), 0, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post_rst_idle", int'(busy), 0, 0);
      measure(lat);
      check("post_rst_lat", lat, 1002, 1002);
      check("post_rst_cnt", int'(count_out), 99, 101);
      accept();
      osc_half = 0;

      // Exact window boundaries on the small instance, synchronous stimulus.
      foreach (vecs[v]) begin
         osc_s = 1'b0;
         repeat (4) @(negedge clk);
         for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 11) check($sformatf("v%0d_valid_early", v), int'(valid_s), 0, 0);
            if (i == 12) begin
               check($sformatf("v%0d_valid", v), int'(valid_s), 1, 1);
               check($sformatf("v%0d_count", v), int'(cout_s), vecs[v].exp_cnt, vecs[v].exp_cnt);
               check($sformatf("v%0d_ovf", v),   int'(ovf_s),  vecs[v].exp_ovf, vecs[v].exp_ovf);
            end
            osc_s   = vecs[v].pat[i];
            start_s = (i == 2);
         end
         @(negedge clk);
         ready_s = 1'b1;
         @(negedge clk);
         ready_s = 1'b0;
         check($sformatf("v%0d_idle", v), int'(busy_s), 0, 0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
